// File: rtl/fetch_scheduler.sv
// fetch_scheduler: lane fetch buffer with demand, sequential and hint
// prefetch scheduling onto a single pipelined instruction memory port.
module fetch_scheduler #(
  parameter int LANES    = 2,
  parameter int DEPTH    = 8,
  parameter int MAX_OUT  = 4,
  parameter int PF_AHEAD = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  init,
  input  logic                  flush,
  input  logic [LANES-1:0]      fetch_order,
  input  logic [32*LANES-1:0]   fetch_pc,
  output logic [LANES-1:0]      fetch_done,
  output logic [32*LANES-1:0]   fetch_instr,
  input  logic [31:0]           fetch_hint,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [31:0]           mem_req_addr,
  input  logic                  mem_resp_valid,
  input  logic [31:0]           mem_resp_data
);

  localparam int DW = $clog2(DEPTH);
  localparam int OW = $clog2(MAX_OUT);
  localparam int SW = $clog2(PF_AHEAD + 1);
  localparam logic [OW:0]   FULL = (OW+1)'(MAX_OUT);
  localparam logic [SW-1:0] PF   = SW'(PF_AHEAD);
  localparam logic [DW-1:0] LAST = DW'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE, DEMAND, SEQ, HINT
  } state_t;

  logic [DEPTH-1:0] vld;
  logic [29:0]      tag [DEPTH];
  logic [31:0]      dat [DEPTH];
  logic [DW-1:0]    victim;

  logic [29:0]        fa [MAX_OUT];
  logic [MAX_OUT-1:0] flive;
  logic [OW-1:0]      head, tail;
  logic [OW:0]        out_cnt;

  state_t        state, state_n;
  logic [31:0]   req_addr, req_addr_n;
  logic [31:0]   seq_pc, seq_pc_n;
  logic [SW-1:0] seq_cnt, seq_cnt_n;
  logic          hint_used, hint_used_n;
  logic [31:0]   hint_prev;

  logic [LANES-1:0] hit;
  logic [31:0]      hdat [LANES];
  logic             miss_any;
  logic [31:0]      miss_pc;
  logic             accept, resp_ok, fill;
  logic [DW-1:0]    fill_idx;
  logic             hint_used_eff;

  // Word is already buffered or live in flight.
  function automatic logic pend(input logic [29:0] w);
    logic r;
    r = 1'b0;
    for (int e = 0; e < DEPTH; e++)
      if (vld[e] && tag[e] == w) r = 1'b1;
    for (int k = 0; k < MAX_OUT; k++)
      if (flive[k] && fa[k] == w) r = 1'b1;
    return r;
  endfunction

  // Per-lane tag match against the buffer.
  always_comb begin
    for (int d = 0; d < LANES; d++) begin
      hit[d]  = 1'b0;
      hdat[d] = '0;
      for (int e = 0; e < DEPTH; e++)
        if (vld[e] && tag[e] == fetch_pc[32*d+2 +: 30]) begin
          hit[d]  = 1'b1;
          hdat[d] = dat[e];
        end
    end
  end

  // In-order done prefix, instr muxing and lowest-lane miss.
  always_comb begin
    logic pre;
    pre      = 1'b1;
    miss_any = 1'b0;
    miss_pc  = '0;
    for (int d = 0; d < LANES; d++) begin
      fetch_done[d] = pre & fetch_order[d] & hit[d];
      pre = fetch_done[d];
      fetch_instr[32*d +: 32] = fetch_done[d] ? hdat[d] : 32'h0;
      if (!miss_any && fetch_order[d] && !hit[d]) begin
        miss_any = 1'b1;
        miss_pc  = fetch_pc[32*d +: 32];
      end
    end
  end

  assign mem_req_valid = (state != IDLE) && (out_cnt != FULL);
  assign mem_req_addr  = req_addr;
  assign accept  = mem_req_valid & mem_req_ready;
  assign resp_ok = mem_resp_valid & (out_cnt != '0);
  assign fill    = resp_ok & flive[head] & ~init;
  assign hint_used_eff = hint_used & (fetch_hint == hint_prev);

  // Fill slot: reuse an entry holding the same tag, else the victim.
  always_comb begin
    fill_idx = victim;
    for (int e = 0; e < DEPTH; e++)
      if (vld[e] && tag[e] == fa[head]) fill_idx = DW'(e);
  end

  // Buffer fill and in-flight address FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld     <= '0;
      victim  <= '0;
      flive   <= '0;
      head    <= '0;
      tail    <= '0;
      out_cnt <= '0;
    end else begin
      if (init) begin
        vld   <= '0;
        flive <= '0;
      end else if (fill) begin
        vld[fill_idx] <= 1'b1;
        tag[fill_idx] <= fa[head];
        dat[fill_idx] <= mem_resp_data;
        victim <= (victim == LAST) ? '0 : victim + 1'b1;
      end
      if (resp_ok) begin
        flive[head] <= 1'b0;
        head <= head + 1'b1;
      end
      if (accept) begin
        fa[tail]    <= mem_req_addr[31:2];
        flive[tail] <= ~init;
        tail <= tail + 1'b1;
      end
      if (accept && !resp_ok) out_cnt <= out_cnt + 1'b1;
      else if (!accept && resp_ok) out_cnt <= out_cnt - 1'b1;
    end
  end

  // Scheduler state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      req_addr  <= '0;
      seq_pc    <= '0;
      seq_cnt   <= PF;
      hint_used <= 1'b0;
      hint_prev <= '0;
    end else begin
      state     <= state_n;
      req_addr  <= req_addr_n;
      seq_pc    <= seq_pc_n;
      seq_cnt   <= seq_cnt_n;
      hint_used <= hint_used_n;
      hint_prev <= fetch_hint;
    end
  end

  // Request selection: demand > sequential > hint.
  always_comb begin
    state_n     = state;
    req_addr_n  = req_addr;
    seq_pc_n    = seq_pc;
    seq_cnt_n   = seq_cnt;
    hint_used_n = hint_used_eff;
    case (state)
      IDLE: begin
        if (miss_any && !pend(miss_pc[31:2])) begin
          state_n    = DEMAND;
          req_addr_n = {miss_pc[31:2], 2'b00};
        end else if (seq_cnt < PF && !flush) begin
          if (pend(seq_pc[31:2])) begin
            seq_pc_n  = seq_pc + 32'd4;
            seq_cnt_n = seq_cnt + 1'b1;
          end else begin
            state_n    = SEQ;
            req_addr_n = seq_pc;
          end
        end else if (!pend(fetch_hint[31:2]) && !hint_used_eff) begin
          state_n    = HINT;
          req_addr_n = {fetch_hint[31:2], 2'b00};
        end
      end
      default: begin
        if (accept) begin
          state_n = IDLE;
          if (state == DEMAND) begin
            seq_pc_n  = req_addr + 32'd4;
            seq_cnt_n = '0;
          end else if (state == SEQ) begin
            seq_pc_n  = seq_pc + 32'd4;
            seq_cnt_n = seq_cnt + 1'b1;
          end else begin
            hint_used_n = 1'b1;
          end
        end else if (flush) begin
          if (state != DEMAND) state_n = IDLE;
          else if (!(miss_any && miss_pc[31:2] == req_addr[31:2]))
            state_n = IDLE;
        end
      end
    endcase
    if (flush) seq_cnt_n = PF;
    if (init) begin
      state_n     = IDLE;
      seq_cnt_n   = PF;
      hint_used_n = 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_scheduler.sv
// tb_fetch_scheduler: directed vectors and multi-cycle sequences
// against a latency-programmable memory responder.
module tb_fetch_scheduler;

  logic        clk = 1'b0;
  logic        rst, init, flush;
  logic [1:0]  order;
  logic [63:0] pc;
  logic [1:0]  done;
  logic [63:0] instr;
  logic [31:0] fhint;
  logic        req_valid, ready;
  logic [31:0] req_addr;
  logic        resp_valid;
  logic [31:0] resp_data;

  fetch_scheduler dut (
    .clk(clk), .rst(rst), .init(init), .flush(flush),
    .fetch_order(order), .fetch_pc(pc),
    .fetch_done(done), .fetch_instr(instr),
    .fetch_hint(fhint),
    .mem_req_valid(req_valid), .mem_req_ready(ready),
    .mem_req_addr(req_addr),
    .mem_resp_valid(resp_valid), .mem_resp_data(resp_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    int          c;
  } pend_t;

  pend_t       q[$];
  logic [31:0] reqlog[$];
  bit          auto_r = 1'b1;
  int          lat = 3;
  int          man_req = 0;
  int          man_done = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    if (a == 32'h100) return 32'h0000_DEAD;
    return a ^ 32'hC0DE_0000;
  endfunction

  function automatic logic [31:0] lg(input int i);
    if (i < reqlog.size()) return reqlog[i];
    return 32'hBAD0_BAD0;
  endfunction

  function automatic int cnt_of(input logic [31:0] a, input int from);
    int n = 0;
    for (int i = from; i < reqlog.size(); i++)
      if (reqlog[i] == a) n++;
    return n;
  endfunction

  // Memory model: logs accepts, answers in order after lat cycles
  // (or on manual demand when auto_r is off).
  initial begin
    int ncyc = 0;
    resp_valid = 1'b0;
    resp_data  = '0;
    forever begin
      @(negedge clk);
      ncyc++;
      resp_valid = 1'b0;
      resp_data  = '0;
      if (q.size() > 0 &&
          ((auto_r && ncyc - q[0].c >= lat) ||
           (!auto_r && man_req > man_done))) begin
        resp_valid = 1'b1;
        resp_data  = data_of(q[0].a);
        void'(q.pop_front());
        if (!auto_r) man_done++;
      end
      if (req_valid && ready && !rst) begin
        q.push_back('{a: req_addr, c: ncyc});
        reqlog.push_back(req_addr);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && q.size() != 0; i++) step();
    chk("drain", 32'(q.size()), 0);
    repeat (4) step();
  endtask

  task automatic comb(input string nm, input logic [1:0] o,
                      input logic [31:0] p0, input logic [31:0] p1,
                      input logic [1:0] ed, input logic [31:0] e0,
                      input logic [31:0] e1);
    @(negedge clk);
    order = o;
    pc = {p1, p0};
    #1;
    chk({nm, "_done"}, 32'(done), 32'(ed));
    chk({nm, "_i0"}, instr[31:0], e0);
    chk({nm, "_i1"}, instr[63:32], e1);
    #1;
    order = 2'b00;
  endtask

  typedef struct {
    logic [1:0]  o;
    logic [31:0] p0, p1;
    logic [1:0]  d;
    logic [31:0] i0, i1;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int base, n, bad;
    tbl[0] = '{2'b00, 32'h100, 32'h104, 2'b00, 0, 0};
    tbl[1] = '{2'b01, 32'h100, 32'h0, 2'b01, 32'hDEAD, 0};
    tbl[2] = '{2'b11, 32'h104, 32'h108, 2'b11,
               32'hC0DE0104, 32'hC0DE0108};
    tbl[3] = '{2'b11, 32'h200, 32'h104, 2'b00, 0, 0};
    tbl[4] = '{2'b01, 32'h10E, 32'h0, 2'b01, 32'hC0DE010C, 0};
    tbl[5] = '{2'b11, 32'h3000, 32'h500, 2'b01, 32'hC0DE3000, 0};
    tbl[6] = '{2'b10, 32'h100, 32'h104, 2'b00, 0, 0};
    tbl[7] = '{2'b11, 32'h10F, 32'h103, 2'b11,
               32'hC0DE010C, 32'hDEAD};

    rst = 1'b1; init = 1'b0; flush = 1'b0;
    order = 2'b01; pc = {32'h0, 32'h100};
    fhint = 32'h3000; ready = 1'b1;
    #12;
    chk("rst_valid", 32'(req_valid), 0);
    chk("rst_addr", req_addr, 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_instr", instr[31:0], 0);
    step();
    rst = 1'b0;

    // cold miss then sequential prefetch
    for (int i = 0; i < 50 && reqlog.size() < 3; i++) step();
    chk("cold_req0", lg(0), 32'h100);
    chk("cold_req1", lg(1), 32'h104);
    chk("cold_req2", lg(2), 32'h108);
    for (int i = 0; i < 50 && done != 2'b01; i++) step();
    chk("cold_done", 32'(done), 32'h1);
    chk("cold_instr", instr[31:0], 32'hDEAD);
    order = 2'b00;
    drain();

    // in-order lanes: lane1 hit waits for lane0
    init = 1'b1; order = 2'b01; pc = {32'h0, 32'h104};
    step();
    init = 1'b0;
    chk("init_clear", 32'(done), 0);
    for (int i = 0; i < 50 && done != 2'b01; i++) step();
    chk("pre_104", 32'(done), 32'h1);
    drain();
    order = 2'b11; pc = {32'h104, 32'h100};
    #1;
    chk("lanes_wait", 32'(done), 0);
    bad = 0;
    for (int i = 0; i < 50 && done != 2'b11; i++) begin
      step();
      if (done == 2'b01 || done == 2'b10) bad++;
    end
    chk("lanes_partial", 32'(bad), 0);
    chk("lanes_done", 32'(done), 32'h3);
    chk("lanes_i0", instr[31:0], 32'hDEAD);
    chk("lanes_i1", instr[63:32], 32'hC0DE0104);
    order = 2'b00;
    drain();
    repeat (6) step();

    for (int i = 0; i < 8; i++)
      comb($sformatf("tbl%0d", i), tbl[i].o, tbl[i].p0,
           tbl[i].p1, tbl[i].d, tbl[i].i0, tbl[i].i1);

    // backpressure and full
    auto_r = 1'b0; ready = 1'b0;
    order = 2'b01; pc = {32'h0, 32'h4000};
    for (int i = 0; i < 10 && !req_valid; i++) step();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(req_valid), 1);
      chk("bp_addr", req_addr, 32'h4000);
      step();
    end
    base = reqlog.size();
    ready = 1'b1;
    for (int i = 0; i < 60 && reqlog.size() - base < 4; i++) begin
      if (reqlog.size() - base >= 3) pc = {32'h0, 32'h6000};
      step();
    end
    chk("full_n", 32'(reqlog.size() - base), 4);
    chk("full_r0", lg(base), 32'h4000);
    chk("full_r1", lg(base + 1), 32'h4004);
    chk("full_r2", lg(base + 2), 32'h4008);
    chk("full_r3", lg(base + 3), 32'h6000);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("full_stall", 32'(req_valid), 0);
    end
    man_req++;
    n = 0;
    for (int i = 0; i < 3 && !req_valid; i++) begin
      step();
      n++;
    end
    chk("full_resume", 32'(req_valid && n <= 2), 1);
    chk("full_next", req_addr, 32'h6004);
    auto_r = 1'b1; order = 2'b00;
    drain();

    // flush drops a held SEQ request
    base = reqlog.size();
    order = 2'b01; pc = {32'h0, 32'h7000};
    for (int i = 0; i < 40 && reqlog.size() - base < 2; i++) step();
    ready = 1'b0;
    chk("fl_r0", lg(base), 32'h7000);
    chk("fl_r1", lg(base + 1), 32'h7004);
    for (int i = 0; i < 10 && !(req_valid && req_addr == 32'h7008); i++)
      step();
    chk("fl_held", 32'(req_valid && req_addr == 32'h7008), 1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fl_drop", 32'(req_valid), 0);
    ready = 1'b1;
    repeat (12) step();
    chk("fl_norepeat", 32'(cnt_of(32'h7008, base)), 0);
    order = 2'b00;
    drain();
    comb("fl_hit", 2'b01, 32'h7004, 0, 2'b01, 32'hC0DE7004, 0);
    comb("fl_miss", 2'b01, 32'h7008, 0, 2'b00, 0, 0);

    // hint once, then wrap of the sequential stream
    base = reqlog.size();
    fhint = 32'h2000;
    repeat (15) step();
    chk("hint_once", 32'(cnt_of(32'h2000, base)), 1);
    n = reqlog.size();
    order = 2'b01; pc = {32'h0, 32'hFFFF_FFFC};
    for (int i = 0; i < 40 && reqlog.size() - n < 3; i++) step();
    chk("wrap_r0", lg(n), 32'hFFFF_FFFC);
    chk("wrap_r1", lg(n + 1), 32'h0);
    chk("wrap_r2", lg(n + 2), 32'h4);
    repeat (10) step();
    chk("hint_still", 32'(cnt_of(32'h2000, base)), 1);
    order = 2'b00;
    drain();
    comb("wrap_hit", 2'b11, 32'hFFFF_FFFC, 32'h0, 2'b11,
         32'h3F21FFFC, 32'hC0DE0000);

    // init with two reads in flight
    auto_r = 1'b0;
    base = reqlog.size();
    order = 2'b01; pc = {32'h0, 32'h8000};
    for (int i = 0; i < 40 && reqlog.size() - base < 2; i++) step();
    ready = 1'b0;
    chk("in_r0", lg(base), 32'h8000);
    chk("in_r1", lg(base + 1), 32'h8004);
    step();
    init = 1'b1; order = 2'b00;
    step();
    init = 1'b0;
    man_req += 2;
    for (int i = 0; i < 20 && q.size() != 0; i++) step();
    chk("in_resp", 32'(q.size()), 0);
    repeat (2) step();
    chk("in_outcnt", 32'(dut.out_cnt), 0);
    chk("in_hint", 32'(req_valid && req_addr == 32'h2000), 1);
    comb("in_8000", 2'b01, 32'h8000, 0, 2'b00, 0, 0);
    comb("in_8004", 2'b01, 32'h8004, 0, 2'b00, 0, 0);
    comb("in_2000", 2'b01, 32'h2000, 0, 2'b00, 0, 0);

    // reset while a request is held
    step();
    rst = 1'b1;
    #1;
    chk("mrst_valid", 32'(req_valid), 0);
    chk("mrst_addr", req_addr, 0);
    step();
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
